// File: rtl/lsu_mem_pipe.sv
// Pipelined load/store unit: in-order request queue, fixed-latency word memory
// access, and CDB request/grant handshake for load results.
module lsu_mem_pipe #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 8,
  parameter int DEPTH   = 4,
  parameter int LATENCY = 3,
  parameter int TAG_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              WEN,
  input  logic [DATA_W-1:0] dataIn1,
  input  logic [DATA_W-1:0] dataIn2,
  input  logic              op,
  input  logic [DATA_W-1:0] writeData,
  input  logic [TAG_W-1:0]  tagIn,
  output logic              available,
  output logic              require,
  input  logic              requireAC,
  output logic [DATA_W-1:0] loadData,
  output logic [TAG_W-1:0]  tagOut,
  output logic              busy
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCESS   = 2'd1,
    WAIT_CDB = 2'd2
  } state_t;

  state_t state_r, state_next_s;

  logic              q_op_r   [DEPTH];
  logic [ADDR_W-1:0] q_idx_r  [DEPTH];
  logic [DATA_W-1:0] q_data_r [DEPTH];
  logic [TAG_W-1:0]  q_tag_r  [DEPTH];
  logic [DATA_W-1:0] mem_r    [0:(1<<ADDR_W)-1];

  logic [PTR_W-1:0]  wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0]  count_r, count_next_s;
  logic              available_r, busy_r, require_r;
  logic [DATA_W-1:0] load_data_r;
  logic [TAG_W-1:0]  tag_out_r;

  logic              ex_op_r;
  logic [ADDR_W-1:0] ex_idx_r;
  logic [DATA_W-1:0] ex_data_r;
  logic [TAG_W-1:0]  ex_tag_r;
  logic [LAT_W-1:0]  cnt_r;

  logic              accept_s, pop_s, mem_we_s, load_done_s, grant_s;
  logic [DATA_W-1:0] ea_s;
  logic [ADDR_W-1:0] idx_s;
  logic              unused_ea_s;

  // Effective address; only the word-index bits are kept.
  assign ea_s        = dataIn1 + dataIn2;
  assign idx_s       = ea_s[ADDR_W+1:2];
  assign unused_ea_s = ^{ea_s[1:0], ea_s[DATA_W-1:ADDR_W+2]};

  // Next-state, pop/complete strobes and queue occupancy.
  always_comb begin
    state_next_s = state_r;
    pop_s        = 1'b0;
    mem_we_s     = 1'b0;
    load_done_s  = 1'b0;
    grant_s      = 1'b0;
    accept_s     = WEN && available_r && rst_n;
    case (state_r)
      IDLE: begin
        if (count_r != CNT_W'(0)) begin
          pop_s        = 1'b1;
          state_next_s = ACCESS;
        end else begin
          state_next_s = IDLE;
        end
      end
      ACCESS: begin
        if (cnt_r == LAT_W'(0)) begin
          if (ex_op_r) begin
            load_done_s  = 1'b1;
            state_next_s = WAIT_CDB;
          end else begin
            mem_we_s     = rst_n;
            state_next_s = IDLE;
          end
        end else begin
          state_next_s = ACCESS;
        end
      end
      WAIT_CDB: begin
        if (requireAC) begin
          grant_s = 1'b1;
          if (count_r != CNT_W'(0)) begin
            pop_s        = 1'b1;
            state_next_s = ACCESS;
          end else begin
            state_next_s = IDLE;
          end
        end else begin
          state_next_s = WAIT_CDB;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
    case ({accept_s, pop_s})
      2'b10:   count_next_s = count_r + CNT_W'(1);
      2'b01:   count_next_s = count_r - CNT_W'(1);
      default: count_next_s = count_r;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Queue pointers, occupancy and the registered status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r    <= PTR_W'(0);
      rd_ptr_r    <= PTR_W'(0);
      count_r     <= CNT_W'(0);
      available_r <= 1'b1;
      busy_r      <= 1'b0;
    end else begin
      if (accept_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (pop_s)    rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      count_r     <= count_next_s;
      available_r <= (count_next_s < CNT_W'(DEPTH));
      busy_r      <= (count_next_s != CNT_W'(0)) || (state_next_s != IDLE);
    end
  end

  // Queue storage; contents are don't-care while the entry is invalid.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      q_op_r[wr_ptr_r]   <= op;
      q_idx_r[wr_ptr_r]  <= idx_s;
      q_data_r[wr_ptr_r] <= writeData;
      q_tag_r[wr_ptr_r]  <= tagIn;
    end
  end

  // Execute register, latency counter and CDB result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_op_r     <= 1'b0;
      ex_idx_r    <= ADDR_W'(0);
      ex_data_r   <= DATA_W'(0);
      ex_tag_r    <= TAG_W'(0);
      cnt_r       <= LAT_W'(0);
      require_r   <= 1'b0;
      load_data_r <= DATA_W'(0);
      tag_out_r   <= TAG_W'(0);
    end else begin
      if (pop_s) begin
        ex_op_r   <= q_op_r[rd_ptr_r];
        ex_idx_r  <= q_idx_r[rd_ptr_r];
        ex_data_r <= q_data_r[rd_ptr_r];
        ex_tag_r  <= q_tag_r[rd_ptr_r];
        cnt_r     <= LAT_W'(LATENCY - 1);
      end else if ((state_r == ACCESS) && (cnt_r != LAT_W'(0))) begin
        cnt_r <= cnt_r - LAT_W'(1);
      end
      if (load_done_s) begin
        load_data_r <= mem_r[ex_idx_r];
        tag_out_r   <= ex_tag_r;
        require_r   <= 1'b1;
      end else if (grant_s) begin
        require_r <= 1'b0;
      end
    end
  end

  // Word memory write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) mem_r[ex_idx_r] <= ex_data_r;
  end

  assign available = available_r;
  assign busy      = busy_r;
  assign require   = require_r;
  assign loadData  = load_data_r;
  assign tagOut    = tag_out_r;

endmodule

// File: tb/tb_lsu_mem_pipe.sv
// Directed bench for lsu_mem_pipe: a transaction-level model checked every
// cycle on the main instance, plus literal expectations and a latency sweep.
module tb_lsu_mem_pipe;

  localparam int DEPTH = 4;
  localparam int LAT   = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wen = 1'b0, wen1 = 1'b0, wen5 = 1'b0;
  logic [31:0] data1 = 32'h0, data2 = 32'h0, wdata = 32'h0;
  logic        op_in = 1'b0;
  logic [3:0]  tag_in = 4'h0;
  logic        req_ac = 1'b0;
  logic        req_ac_hi = 1'b1;

  logic        available, require, busy;
  logic [31:0] load_data;
  logic [3:0]  tag_out;
  logic        available1, require1, busy1;
  logic [31:0] load_data1;
  logic [3:0]  tag_out1;
  logic        available5, require5, busy5;
  logic [31:0] load_data5;
  logic [3:0]  tag_out5;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int t_acc = 0;
  int t_grant = 0;
  int w = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  lsu_mem_pipe #(.DATA_W(32), .ADDR_W(8), .DEPTH(DEPTH), .LATENCY(LAT), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .WEN(wen), .dataIn1(data1), .dataIn2(data2), .op(op_in),
    .writeData(wdata), .tagIn(tag_in), .available(available), .require(require),
    .requireAC(req_ac), .loadData(load_data), .tagOut(tag_out), .busy(busy));

  lsu_mem_pipe #(.DATA_W(32), .ADDR_W(8), .DEPTH(DEPTH), .LATENCY(1), .TAG_W(4)) dut_l1 (
    .clk(clk), .rst_n(rst_n), .WEN(wen1), .dataIn1(data1), .dataIn2(data2), .op(op_in),
    .writeData(wdata), .tagIn(tag_in), .available(available1), .require(require1),
    .requireAC(req_ac_hi), .loadData(load_data1), .tagOut(tag_out1), .busy(busy1));

  lsu_mem_pipe #(.DATA_W(32), .ADDR_W(8), .DEPTH(DEPTH), .LATENCY(5), .TAG_W(4)) dut_l5 (
    .clk(clk), .rst_n(rst_n), .WEN(wen5), .dataIn1(data1), .dataIn2(data2), .op(op_in),
    .writeData(wdata), .tagIn(tag_in), .available(available5), .require(require5),
    .requireAC(req_ac_hi), .loadData(load_data5), .tagOut(tag_out5), .busy(busy5));

  typedef struct {
    bit         ld;
    logic [7:0] idx;
    logic [31:0] d;
    logic [3:0] tg;
  } req_t;

  req_t        mq[$];
  req_t        cur;
  int          ph = 0;     // 0 idle, 1 accessing, 2 waiting for grant
  int          left = 0;   // access edges still to go
  bit          m_req = 1'b0;
  logic [31:0] m_ld = 32'h0;
  logic [3:0]  m_tag = 4'h0;
  logic [31:0] m_mem [256];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_step();
    int sz;
    logic [31:0] ea;
    req_t r;
    if (!rst_n) begin
      mq.delete();
      ph = 0; m_req = 1'b0; m_ld = 32'h0; m_tag = 4'h0;
    end else begin
      sz = mq.size();
      case (ph)
        0: if (sz > 0) begin cur = mq.pop_front(); ph = 1; left = LAT; end
        1: begin
          left--;
          if (left == 0) begin
            if (cur.ld) begin m_ld = m_mem[cur.idx]; m_tag = cur.tg; m_req = 1'b1; ph = 2; end
            else begin m_mem[cur.idx] = cur.d; ph = 0; end
          end
        end
        2: if (req_ac) begin
          m_req = 1'b0;
          if (sz > 0) begin cur = mq.pop_front(); ph = 1; left = LAT; end
          else ph = 0;
        end
        default: ph = 0;
      endcase
      if (wen && sz < DEPTH) begin
        ea = data1 + data2;
        r.ld = op_in; r.idx = ea[9:2]; r.d = wdata; r.tg = tag_in;
        mq.push_back(r);
      end
    end
  endtask

  task automatic compare_all();
    check("require", require, m_req);
    check("available", available, mq.size() < DEPTH);
    check("busy", busy, (mq.size() != 0) || (ph != 0));
    check("loadData", load_data, m_ld);
    check("tagOut", tag_out, m_tag);
  endtask

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) model_step();
  always @(negedge clk) if (chk_en) compare_all();

  function automatic logic get_req(input int which);
    return (which == 0) ? require : (which == 1) ? require1 : require5;
  endfunction
  function automatic logic get_busy(input int which);
    return (which == 0) ? busy : (which == 1) ? busy1 : busy5;
  endfunction
  function automatic logic [31:0] get_ld(input int which);
    return (which == 0) ? load_data : (which == 1) ? load_data1 : load_data5;
  endfunction

  task automatic drive(input int which, input bit is_ld, input logic [31:0] b,
                       input logic [31:0] off, input logic [31:0] wd, input logic [3:0] t);
    @(negedge clk);
    wen = (which == 0); wen1 = (which == 1); wen5 = (which == 2);
    op_in = is_ld; data1 = b; data2 = off; wdata = wd; tag_in = t;
    t_acc = cyc + 1;
  endtask

  task automatic stop_wen();
    @(negedge clk);
    wen = 1'b0; wen1 = 1'b0; wen5 = 1'b0;
  endtask

  task automatic wait_req(input int which, output int when);
    when = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (get_req(which)) begin when = cyc; break; end
    end
    if (when < 0) check("require_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_idle(input int which);
    bit done = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!get_busy(which)) begin done = 1'b1; break; end
    end
    if (!done) check("idle_timeout", 64'd0, 64'd1);
  endtask

  task automatic grant();
    req_ac = 1'b1;
    t_grant = cyc + 1;
    @(negedge clk);
    req_ac = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;
    check("rst_available", available, 64'd1);
    check("rst_busy", busy, 64'd0);
    check("rst_require", require, 64'd0);

    // Store then load the same word
    drive(0, 1'b0, 32'd4, 32'd8, 32'h12345678, 4'd1);
    stop_wen();
    wait_idle(0);
    check("t1_store_noreq", require, 64'd0);
    drive(0, 1'b1, 32'd4, 32'd8, 32'h0, 4'd2);
    stop_wen();
    wait_req(0, w);
    check("t1_latency", 64'(w - t_acc), 64'd4);
    check("t1_data", load_data, 64'h12345678);
    check("t1_tag", tag_out, 64'd2);
    grant();
    wait_idle(0);

    // Fill words 10..14, then flood loads with no grant
    for (int i = 0; i < 5; i++) begin
      drive(0, 1'b0, 32'(4 * (10 + i)), 32'd0, 32'h10000000 + 32'(i), 4'd0);
      stop_wen();
      wait_idle(0);
    end
    for (int i = 0; i < DEPTH + 2; i++)
      drive(0, 1'b1, 32'(4 * (10 + (i % 5))), 32'd0, 32'h0, 4'(3 + i));
    check("t2_full", available, 64'd0);
    stop_wen();
    for (int k = 0; k < 5; k++) begin
      wait_req(0, w);
      if (k > 0) check("t3_grant_to_req", 64'(w - t_grant), 64'd3);
      check("t2_tag", tag_out, 64'(3 + k));
      check("t2_data", load_data, 64'h10000000 + 64'(k));
      if (k == 0) begin
        for (int s = 0; s < 10; s++) begin
          @(negedge clk);
          check("t3_stall_req", require, 64'd1);
          check("t3_stall_data", load_data, 64'h10000000);
          check("t3_stall_tag", tag_out, 64'd3);
        end
      end
      grant();
      check("t3_req_drop", require, 64'd0);
      if (k < 4) check("t3_busy", busy, 64'd1);
    end
    wait_idle(0);

    // Address wrap and ignored high index bits
    drive(0, 1'b0, 32'hFFFFFFFC, 32'd8, 32'hA5A5A5A5, 4'd8);
    stop_wen();
    wait_idle(0);
    drive(0, 1'b1, 32'd0, 32'd4, 32'h0, 4'd9);
    stop_wen();
    wait_req(0, w);
    check("t4_wrap_data", load_data, 64'hA5A5A5A5);
    check("t4_wrap_tag", tag_out, 64'd9);
    grant();
    drive(0, 1'b1, 32'h407, 32'd0, 32'h0, 4'd10);
    stop_wen();
    wait_req(0, w);
    check("t4_high_bits", load_data, 64'hA5A5A5A5);
    grant();
    wait_idle(0);

    // Reset during a store's access phase
    drive(0, 1'b0, 32'd12, 32'd0, 32'h11111111, 4'd0);
    stop_wen();
    wait_idle(0);
    drive(0, 1'b0, 32'd12, 32'd0, 32'hDEADBEEF, 4'd0);
    stop_wen();
    @(negedge clk);
    check("t5_in_access", busy, 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("t5_rst_require", require, 64'd0);
    check("t5_rst_data", load_data, 64'd0);
    check("t5_rst_tag", tag_out, 64'd0);
    check("t5_rst_available", available, 64'd1);
    check("t5_rst_busy", busy, 64'd0);
    drive(0, 1'b1, 32'd12, 32'd0, 32'h0, 4'd11);
    stop_wen();
    wait_req(0, w);
    check("t5_old_data", load_data, 64'h11111111);
    grant();
    wait_idle(0);

    // Latency sweep on the LATENCY=1 and LATENCY=5 instances
    for (int which = 1; which <= 2; which++) begin
      drive(which, 1'b0, 32'd4, 32'd8, 32'h12345678, 4'd1);
      stop_wen();
      wait_idle(which);
      drive(which, 1'b1, 32'd4, 32'd8, 32'h0, 4'd2);
      stop_wen();
      wait_req(which, w);
      check(which == 1 ? "t6_lat1" : "t6_lat5", 64'(w - t_acc), which == 1 ? 64'd2 : 64'd6);
      check("t6_data", get_ld(which), 64'h12345678);
      wait_idle(which);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
